ym_bus_sched: RTL
=================

// Module: ym_bus_sched
// PURPOSE
//  Arbitrates YM2151 register writes from two requesters (CPU path, UART direct-dump path) into one queue.
//  Executes each queued write on the real YM2151 pins: busy-flag poll, address write (A0=0), data write (A0=1).
//  Sits between the system bus and the ym_* pads/level shifters. Replaces ad-hoc CPU bit-banging of cs_n/wr_n/rd_n.
// PARAMETERS
//  FIFO_AW    4     log2 of queue depth (16 entries of {reg[7:0],val[7:0]})
//  T_SETUP    2     clk cycles A0/D/DIR stable before strobe falls (>=1)
//  T_PULSE    6     clk cycles cs_n+wr_n or cs_n+rd_n held low (>=1)
//  T_HOLD     2     clk cycles A0/D held after strobe rises (>=1)
//  POLL_MAX   2048  busy polls before giving up on one entry (>=1)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  cpu_req     in   1  CPU write request; held until cpu_ack
//  cpu_reg     in   8  CPU YM register address
//  cpu_val     in   8  CPU YM register value
//  cpu_ack     out  1  one-cycle pulse: CPU entry enqueued
//  uart_req    in   1  UART write request; held until uart_ack
//  uart_reg    in   8  UART YM register address
//  uart_val    in   8  UART YM register value
//  uart_ack    out  1  one-cycle pulse: UART entry enqueued
//  fifo_full   out  1  queue holds 2**FIFO_AW entries
//  idle        out  1  queue empty and sequencer in IDLE
//  ym_d_o      out  8  data to YM pads
//  ym_d_i      in   8  data from YM pads (status on read)
//  ym_d_oe     out  1  pad output enable, equals ~dir
//  ym_a0       out  1  YM A0
//  ym_cs_n     out  1  YM chip select, active low
//  ym_wr_n     out  1  YM write strobe, active low
//  ym_rd_n     out  1  YM read strobe, active low
//  dir         out  1  level shifter: 0 FPGA drives YM, 1 FPGA reads YM
//  poll_tmo    out  1  sticky: an entry was written after POLL_MAX busy polls
//  poll_tmo_clr in  1  clears poll_tmo
// BEHAVIOUR
//  Reset (async, rst_n=0): queue emptied, FSM=IDLE, last_grant=UART; outputs: acks 0, fifo_full 0, idle 1,
//   ym_cs_n/wr_n/rd_n 1, ym_a0 0, ym_d_o 0, dir 1, ym_d_oe 0, poll_tmo 0. Reset mid-cycle aborts entry; strobes rise at once.
//  Arbitration (per clk): push allowed iff !fifo_full. One req only -> ack it. Both -> grant the one not in last_grant,
//   then update last_grant. Ack asserted the cycle the entry is written; requester drops req next cycle.
//   A req still high the cycle after its ack is a new request (requester contract: drop req after ack).
//  Queue: pointers FIFO_AW bits, count FIFO_AW+1 bits; push and pop in same cycle allowed (count unchanged, works when full).
//  FSM (one counter cnt reused for SETUP/PULSE/HOLD phases; polls counted separately in pcnt):
//   IDLE:      queue non-empty -> P_SETUP, pcnt=0.
//   P_SETUP:   dir=1, oe=0, a0=1, strobes high; T_SETUP cycles -> P_PULSE.
//   P_PULSE:   cs_n=0, rd_n=0 for T_PULSE cycles; ym_d_i[7] registered on last pulse cycle -> P_HOLD.
//   P_HOLD:    strobes high, T_HOLD cycles; then busy=1 and pcnt<POLL_MAX-1 -> P_SETUP (pcnt++);
//              busy=1 and pcnt==POLL_MAX-1 -> set poll_tmo, go A_SETUP; busy=0 -> A_SETUP.
//   A_SETUP:   dir=0, oe=1, a0=0, ym_d_o=head.reg; T_SETUP cycles -> A_PULSE.
//   A_PULSE:   cs_n=0, wr_n=0 for T_PULSE cycles -> A_HOLD (T_HOLD cycles) -> D_SETUP.
//   D_SETUP:   a0=1, ym_d_o=head.val; T_SETUP -> D_PULSE (T_PULSE) -> D_HOLD (T_HOLD) -> pop entry -> IDLE.
//  dir/oe change only in *_SETUP states, never while cs_n=0; rd_n and wr_n never low together.
//  Write latency, empty queue, YM not busy: push at cycle 0 -> first cs_n fall at 1+1+T_SETUP;
//   entry pops after 3*(T_SETUP+T_PULSE+T_HOLD) cycles in P/A/D phases plus 1 IDLE cycle.
//  poll_tmo: set and poll_tmo_clr same cycle -> set wins. idle = empty & FSM==IDLE (registered).
// TESTING
//  1 cpu_req reg=0x20 val=0xC7, ym_d_i=0x00 -> cpu_ack next cycle; one rd cycle a0=1, then wr a0=0 d=0x20, wr a0=1 d=0xC7; idle=1 after.
//  2 cpu_req and uart_req same cycle, repeatedly -> grants alternate CPU,UART,CPU...; YM writes appear in grant order.
//  3 ym_d_i[7]=1 for 5 polls then 0 -> exactly 6 rd strobes before address write; poll_tmo stays 0.
//  4 POLL_MAX=4, ym_d_i=0x80 forever -> 4 rd strobes, then write proceeds, poll_tmo=1; poll_tmo_clr -> 0.
//  5 fill 16 entries with YM busy -> fifo_full=1, further req un-acked; on first pop, pending req acked same cycle; count stays 16.
//  6 rst_n low during A_PULSE -> cs_n/wr_n=1 immediately, dir=1, queue empty, idle=1; no further strobes after release.

Source files
------------

// File: rtl/ym_bus_sched_if.sv
// Bundle of requester handshakes and YM2151 pad signals for ym_bus_sched.
// The slave modport is the scheduler; the master modport is the bus/pad side.
interface ym_bus_sched_if;
  logic       cpu_req;
  logic [7:0] cpu_reg;
  logic [7:0] cpu_val;
  logic       cpu_ack;
  logic       uart_req;
  logic [7:0] uart_reg;
  logic [7:0] uart_val;
  logic       uart_ack;
  logic       fifo_full;
  logic       idle;
  logic [7:0] ym_d_o;
  logic [7:0] ym_d_i;
  logic       ym_d_oe;
  logic       ym_a0;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic       ym_rd_n;
  logic       dir;
  logic       poll_tmo;
  logic       poll_tmo_clr;

  modport slave (
    input  cpu_req, cpu_reg, cpu_val, uart_req, uart_reg, uart_val, ym_d_i, poll_tmo_clr,
    output cpu_ack, uart_ack, fifo_full, idle, ym_d_o, ym_d_oe, ym_a0, ym_cs_n, ym_wr_n,
           ym_rd_n, dir, poll_tmo
  );

  modport master (
    output cpu_req, cpu_reg, cpu_val, uart_req, uart_reg, uart_val, ym_d_i, poll_tmo_clr,
    input  cpu_ack, uart_ack, fifo_full, idle, ym_d_o, ym_d_oe, ym_a0, ym_cs_n, ym_wr_n,
           ym_rd_n, dir, poll_tmo
  );
endinterface

// File: rtl/ym_bus_sched.sv
// Queues YM2151 register writes from CPU and UART requesters and plays each one
// out on the chip pins as busy poll, address write, data write.
//  state     | meaning
//  IDLE      | wait for a queued entry
//  P_*       | status read (setup / rd strobe / hold), repeated while busy
//  A_*       | address write, A0=0
//  D_*       | data write, A0=1; entry popped at end of D_HOLD
module ym_bus_sched #(
  parameter int FIFO_AW  = 4,
  parameter int T_SETUP  = 2,
  parameter int T_PULSE  = 6,
  parameter int T_HOLD   = 2,
  parameter int POLL_MAX = 2048
) (
  input  logic          clk,
  input  logic          rst_n,
  ym_bus_sched_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = 16;
  localparam int PW    = $clog2(POLL_MAX + 1);
  localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [CW-1:0]      SETUP_M1 = CW'(T_SETUP - 1);
  localparam logic [CW-1:0]      PULSE_M1 = CW'(T_PULSE - 1);
  localparam logic [CW-1:0]      HOLD_M1  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0]      TMR_ONE  = CW'(1);
  localparam logic [PW-1:0]      PMAX_M1  = PW'(POLL_MAX - 1);
  localparam logic [PW-1:0]      POLL_ONE = PW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_P_SETUP, S_P_PULSE, S_P_HOLD,
    S_A_SETUP, S_A_PULSE, S_A_HOLD,
    S_D_SETUP, S_D_PULSE, S_D_HOLD
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [PW-1:0]      r_pcnt, w_pcnt_nxt;
  logic               r_busy, r_dir, r_tmo, r_idle, r_last_uart;
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_count, w_count_nxt;
  logic [15:0]        r_mem [DEPTH];

  logic        w_full, w_empty, w_space, w_push, w_pop;
  logic        w_cpu_gnt, w_uart_gnt, w_done, w_set_tmo, w_busy_cap;
  logic [15:0] w_push_data, w_head;
  logic        w_cs_n, w_rd_n, w_wr_n, w_a0;
  logic [7:0]  w_d_o;
  logic        w_unused;

  assign w_unused = ^bus.ym_d_i[6:0];

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_space    = !w_full || w_pop;
  assign w_cpu_gnt  = w_space && bus.cpu_req && (!bus.uart_req || r_last_uart);
  assign w_uart_gnt = w_space && bus.uart_req && !w_cpu_gnt;
  assign w_push     = w_cpu_gnt || w_uart_gnt;
  assign w_push_data = w_cpu_gnt ? {bus.cpu_reg, bus.cpu_val} : {bus.uart_reg, bus.uart_val};
  assign w_head      = r_mem[r_rptr];
  assign w_done      = (r_cnt == '0);

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pcnt_nxt  = r_pcnt;
    w_pop       = 1'b0;
    w_set_tmo   = 1'b0;
    w_busy_cap  = 1'b0;
    if (r_state != S_IDLE && !w_done) w_cnt_nxt = r_cnt - TMR_ONE;
    unique case (r_state)
      S_IDLE: if (!w_empty) begin
        w_state_nxt = S_P_SETUP;
        w_cnt_nxt   = SETUP_M1;
        w_pcnt_nxt  = '0;
      end
      S_P_SETUP: if (w_done) begin w_state_nxt = S_P_PULSE; w_cnt_nxt = PULSE_M1; end
      S_P_PULSE: if (w_done) begin
        w_state_nxt = S_P_HOLD;
        w_cnt_nxt   = HOLD_M1;
        w_busy_cap  = 1'b1;
      end
      S_P_HOLD: if (w_done) begin
        w_cnt_nxt = SETUP_M1;
        if (r_busy && r_pcnt != PMAX_M1) begin
          w_state_nxt = S_P_SETUP;
          w_pcnt_nxt  = r_pcnt + POLL_ONE;
        end else begin
          w_state_nxt = S_A_SETUP;
          w_set_tmo   = r_busy;
        end
      end
      S_A_SETUP: if (w_done) begin w_state_nxt = S_A_PULSE; w_cnt_nxt = PULSE_M1; end
      S_A_PULSE: if (w_done) begin w_state_nxt = S_A_HOLD;  w_cnt_nxt = HOLD_M1;  end
      S_A_HOLD:  if (w_done) begin w_state_nxt = S_D_SETUP; w_cnt_nxt = SETUP_M1; end
      S_D_SETUP: if (w_done) begin w_state_nxt = S_D_PULSE; w_cnt_nxt = PULSE_M1; end
      S_D_PULSE: if (w_done) begin w_state_nxt = S_D_HOLD;  w_cnt_nxt = HOLD_M1;  end
      S_D_HOLD:  if (w_done) begin w_state_nxt = S_IDLE;    w_pop     = 1'b1;     end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cs_n = 1'b1;
    w_rd_n = 1'b1;
    w_wr_n = 1'b1;
    w_a0   = 1'b0;
    w_d_o  = '0;
    unique case (r_state)
      S_P_SETUP, S_P_HOLD: w_a0 = 1'b1;
      S_P_PULSE: begin w_a0 = 1'b1; w_cs_n = 1'b0; w_rd_n = 1'b0; end
      S_A_SETUP, S_A_HOLD: w_d_o = w_head[15:8];
      S_A_PULSE: begin w_d_o = w_head[15:8]; w_cs_n = 1'b0; w_wr_n = 1'b0; end
      S_D_SETUP, S_D_HOLD: begin w_a0 = 1'b1; w_d_o = w_head[7:0]; end
      S_D_PULSE: begin w_a0 = 1'b1; w_d_o = w_head[7:0]; w_cs_n = 1'b0; w_wr_n = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pcnt      <= '0;
      r_busy      <= 1'b0;
      r_dir       <= 1'b1;
      r_tmo       <= 1'b0;
      r_idle      <= 1'b1;
      r_last_uart <= 1'b1;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_count <= w_count_nxt;
      r_idle  <= (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
      if (w_busy_cap) r_busy <= bus.ym_d_i[7];
      // Direction only turns around on entry to a setup phase, never mid-strobe.
      if (w_state_nxt == S_P_SETUP)      r_dir <= 1'b1;
      else if (w_state_nxt == S_A_SETUP) r_dir <= 1'b0;
      if (w_set_tmo)             r_tmo <= 1'b1;
      else if (bus.poll_tmo_clr) r_tmo <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_cpu_gnt)       r_last_uart <= 1'b0;
      else if (w_uart_gnt) r_last_uart <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  assign bus.cpu_ack   = w_cpu_gnt;
  assign bus.uart_ack  = w_uart_gnt;
  assign bus.fifo_full = w_full;
  assign bus.idle      = r_idle;
  assign bus.ym_d_o    = w_d_o;
  assign bus.ym_d_oe   = !r_dir;
  assign bus.ym_a0     = w_a0;
  assign bus.ym_cs_n   = w_cs_n;
  assign bus.ym_wr_n   = w_wr_n;
  assign bus.ym_rd_n   = w_rd_n;
  assign bus.dir       = r_dir;
  assign bus.poll_tmo  = r_tmo;
endmodule
